// File: rtl/cpu_pkg.sv
// Shared pipeline types: default widths, the hard-wired zero register index,
// forward-source select encoding and the operand packet layout handed to EX.
package cpu_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int CTRL_WIDTH_DEF = 16;

   localparam logic [ADDR_WIDTH_DEF-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] a;
      logic [DATA_WIDTH_DEF-1:0] b;
      logic [ADDR_WIDTH_DEF-1:0] rd;
      logic                      regwr;
      logic                      isload;
      logic [CTRL_WIDTH_DEF-1:0] ctrl;
   } op_packet_t;

endpackage

// File: rtl/operand_forward_mux.sv
// One source operand: hazard match against EX/MEM/WB, priority select, stall request.
// Combinational. OPFETCH_FORWARD_EN selects forwarding; otherwise every hazard stalls.
module operand_forward_mux
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  use_src,
   input  logic [ADDR_WIDTH-1:0] rs,
   input  logic [DATA_WIDTH-1:0] rf_dat,
   input  logic [ADDR_WIDTH-1:0] ex_rd,
   input  logic                  ex_regwr,
   input  logic                  ex_isload,
   input  logic [DATA_WIDTH-1:0] ex_dat,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic                  mem_regwr,
   input  logic [DATA_WIDTH-1:0] mem_dat,
   input  logic [ADDR_WIDTH-1:0] wb_rd,
   input  logic                  wb_regwr,
   input  logic [DATA_WIDTH-1:0] wb_dat,
   output logic [DATA_WIDTH-1:0] op_dat,
   output logic                  stall_req
);

   logic src_live;
   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   // x0 is never a hazard and always reads as zero, as does an unused operand
   assign src_live = use_src & (rs != ADDR_WIDTH'(ZERO_REG));
   assign ex_hit   = src_live & ex_regwr  & (ex_rd  == rs);
   assign mem_hit  = src_live & mem_regwr & (mem_rd == rs);
   assign wb_hit   = src_live & wb_regwr  & (wb_rd  == rs);

`ifdef OPFETCH_FORWARD_EN
   fwd_sel_e sel;

   always_comb begin
      sel = FWD_RF;
      if (ex_hit)
         sel = FWD_EX;
      else if (mem_hit)
         sel = FWD_MEM;
      else if (wb_hit)
         sel = FWD_WB;
   end

   always_comb begin
      op_dat = '0;
      if (src_live) begin
         case (sel)
            FWD_EX:  op_dat = ex_dat;
            FWD_MEM: op_dat = mem_dat;
            FWD_WB:  op_dat = wb_dat;
            default: op_dat = rf_dat;
         endcase
      end
   end

   // A load in EX has no result yet, so only that case needs a bubble
   assign stall_req = ex_hit & ex_isload;
`else
   logic unused_fwd;

   assign unused_fwd = ^{ex_isload, ex_dat, mem_dat, wb_dat};
   assign op_dat     = src_live ? rf_dat : '0;
   assign stall_req  = ex_hit | mem_hit | wb_hit;
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: drives RF read ports, resolves RAW hazards, registers the packet for EX
// (1 cycle accept-to-valid, packet held under ~i_OpReady). Forwarding gated by OPFETCH_FORWARD_EN.
module operand_fetch_stage
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int CTRL_WIDTH = CTRL_WIDTH_DEF
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_Flush,
   input  logic                  i_InstValid,
   output logic                  o_InstReady,
   input  logic [ADDR_WIDTH-1:0] i_InstRs1,
   input  logic [ADDR_WIDTH-1:0] i_InstRs2,
   input  logic                  i_InstUseRs1,
   input  logic                  i_InstUseRs2,
   input  logic [ADDR_WIDTH-1:0] i_InstRd,
   input  logic                  i_InstRegWr,
   input  logic                  i_InstIsLoad,
   input  logic [CTRL_WIDTH-1:0] i_InstCtrl,
   output logic [ADDR_WIDTH-1:0] o_RdAddrA,
   output logic [ADDR_WIDTH-1:0] o_RdAddrB,
   input  logic [DATA_WIDTH-1:0] i_RdDataA,
   input  logic [DATA_WIDTH-1:0] i_RdDataB,
   input  logic [ADDR_WIDTH-1:0] i_ExRd,
   input  logic [ADDR_WIDTH-1:0] i_MemRd,
   input  logic [ADDR_WIDTH-1:0] i_WbRd,
   input  logic                  i_ExRegWr,
   input  logic                  i_MemRegWr,
   input  logic                  i_WbRegWr,
   input  logic                  i_ExIsLoad,
   input  logic [DATA_WIDTH-1:0] i_ExResult,
   input  logic [DATA_WIDTH-1:0] i_MemResult,
   input  logic [DATA_WIDTH-1:0] i_WbData,
   output logic                  o_OpValid,
   input  logic                  i_OpReady,
   output logic [DATA_WIDTH-1:0] o_OpA,
   output logic [DATA_WIDTH-1:0] o_OpB,
   output logic [ADDR_WIDTH-1:0] o_OpRd,
   output logic                  o_OpRegWr,
   output logic                  o_OpIsLoad,
   output logic [CTRL_WIDTH-1:0] o_OpCtrl
);

   logic [DATA_WIDTH-1:0] res_a;
   logic [DATA_WIDTH-1:0] res_b;
   logic                  stall_a;
   logic                  stall_b;
   logic                  stall;
   logic                  accept;

   logic                  op_vld_q,    op_vld_d;
   logic [DATA_WIDTH-1:0] op_a_q,      op_a_d;
   logic [DATA_WIDTH-1:0] op_b_q,      op_b_d;
   logic [ADDR_WIDTH-1:0] op_rd_q,     op_rd_d;
   logic                  op_regwr_q,  op_regwr_d;
   logic                  op_isload_q, op_isload_d;
   logic [CTRL_WIDTH-1:0] op_ctrl_q,   op_ctrl_d;

   assign o_RdAddrA = i_InstRs1;
   assign o_RdAddrB = i_InstRs2;

   operand_forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
      .use_src  (i_InstUseRs1),
      .rs       (i_InstRs1),
      .rf_dat   (i_RdDataA),
      .ex_rd    (i_ExRd),
      .ex_regwr (i_ExRegWr),
      .ex_isload(i_ExIsLoad),
      .ex_dat   (i_ExResult),
      .mem_rd   (i_MemRd),
      .mem_regwr(i_MemRegWr),
      .mem_dat  (i_MemResult),
      .wb_rd    (i_WbRd),
      .wb_regwr (i_WbRegWr),
      .wb_dat   (i_WbData),
      .op_dat   (res_a),
      .stall_req(stall_a)
   );

   operand_forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
      .use_src  (i_InstUseRs2),
      .rs       (i_InstRs2),
      .rf_dat   (i_RdDataB),
      .ex_rd    (i_ExRd),
      .ex_regwr (i_ExRegWr),
      .ex_isload(i_ExIsLoad),
      .ex_dat   (i_ExResult),
      .mem_rd   (i_MemRd),
      .mem_regwr(i_MemRegWr),
      .mem_dat  (i_MemResult),
      .wb_rd    (i_WbRd),
      .wb_regwr (i_WbRegWr),
      .wb_dat   (i_WbData),
      .op_dat   (res_b),
      .stall_req(stall_b)
   );

   // Ready never looks at i_InstValid, keeping the handshake free of comb loops
   assign stall       = stall_a | stall_b;
   assign o_InstReady = ~stall & ~i_Flush & (~op_vld_q | i_OpReady);
   assign accept      = i_InstValid & o_InstReady;

   always_comb begin
      op_vld_d    = op_vld_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_rd_d     = op_rd_q;
      op_regwr_d  = op_regwr_q;
      op_isload_d = op_isload_q;
      op_ctrl_d   = op_ctrl_q;
      if (accept) begin
         op_a_d      = res_a;
         op_b_d      = res_b;
         op_rd_d     = i_InstRd;
         op_regwr_d  = i_InstRegWr;
         op_isload_d = i_InstIsLoad;
         op_ctrl_d   = i_InstCtrl;
      end
      if (i_Flush)
         op_vld_d = 1'b0;
      else if (accept)
         op_vld_d = 1'b1;
      else if (op_vld_q & i_OpReady)
         op_vld_d = 1'b0;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         op_vld_q    <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_rd_q     <= '0;
         op_regwr_q  <= 1'b0;
         op_isload_q <= 1'b0;
         op_ctrl_q   <= '0;
      end else begin
         op_vld_q    <= op_vld_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_rd_q     <= op_rd_d;
         op_regwr_q  <= op_regwr_d;
         op_isload_q <= op_isload_d;
         op_ctrl_q   <= op_ctrl_d;
      end
   end

   assign o_OpValid  = op_vld_q;
   assign o_OpA      = op_a_q;
   assign o_OpB      = op_b_q;
   assign o_OpRd     = op_rd_q;
   assign o_OpRegWr  = op_regwr_q;
   assign o_OpIsLoad = op_isload_q;
   assign o_OpCtrl   = op_ctrl_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage; expectations follow OPFETCH_FORWARD_EN.
module tb_operand_fetch_stage;

   logic        i_Clock = 1'b0;
   logic        i_Reset, i_Flush, i_InstValid, o_InstReady;
   logic [4:0]  i_InstRs1, i_InstRs2, i_InstRd;
   logic        i_InstUseRs1, i_InstUseRs2, i_InstRegWr, i_InstIsLoad;
   logic [15:0] i_InstCtrl;
   logic [4:0]  o_RdAddrA, o_RdAddrB;
   logic [31:0] i_RdDataA, i_RdDataB;
   logic [4:0]  i_ExRd, i_MemRd, i_WbRd;
   logic        i_ExRegWr, i_MemRegWr, i_WbRegWr, i_ExIsLoad;
   logic [31:0] i_ExResult, i_MemResult, i_WbData;
   logic        o_OpValid, i_OpReady;
   logic [31:0] o_OpA, o_OpB;
   logic [4:0]  o_OpRd;
   logic        o_OpRegWr, o_OpIsLoad;
   logic [15:0] o_OpCtrl;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

`ifdef OPFETCH_FORWARD_EN
   localparam logic [31:0] EXP_B_HOLD = 32'h1234;
`else
   localparam logic [31:0] EXP_B_HOLD = 32'h9999;
`endif

   always #5 i_Clock = ~i_Clock;

   operand_fetch_stage dut (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Flush(i_Flush),
      .i_InstValid(i_InstValid), .o_InstReady(o_InstReady),
      .i_InstRs1(i_InstRs1), .i_InstRs2(i_InstRs2),
      .i_InstUseRs1(i_InstUseRs1), .i_InstUseRs2(i_InstUseRs2),
      .i_InstRd(i_InstRd), .i_InstRegWr(i_InstRegWr), .i_InstIsLoad(i_InstIsLoad),
      .i_InstCtrl(i_InstCtrl),
      .o_RdAddrA(o_RdAddrA), .o_RdAddrB(o_RdAddrB),
      .i_RdDataA(i_RdDataA), .i_RdDataB(i_RdDataB),
      .i_ExRd(i_ExRd), .i_MemRd(i_MemRd), .i_WbRd(i_WbRd),
      .i_ExRegWr(i_ExRegWr), .i_MemRegWr(i_MemRegWr), .i_WbRegWr(i_WbRegWr),
      .i_ExIsLoad(i_ExIsLoad),
      .i_ExResult(i_ExResult), .i_MemResult(i_MemResult), .i_WbData(i_WbData),
      .o_OpValid(o_OpValid), .i_OpReady(i_OpReady),
      .o_OpA(o_OpA), .o_OpB(o_OpB), .o_OpRd(o_OpRd),
      .o_OpRegWr(o_OpRegWr), .o_OpIsLoad(o_OpIsLoad), .o_OpCtrl(o_OpCtrl)
   );

   task automatic step();
      @(posedge i_Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      i_Reset = 1'b1; i_Flush = 1'b0; i_InstValid = 1'b0; i_OpReady = 1'b1;
      i_InstRs1 = '0; i_InstRs2 = '0; i_InstUseRs1 = 1'b0; i_InstUseRs2 = 1'b0;
      i_InstRd = '0; i_InstRegWr = 1'b0; i_InstIsLoad = 1'b0; i_InstCtrl = '0;
      i_RdDataA = '0; i_RdDataB = '0;
      i_ExRd = '0; i_MemRd = '0; i_WbRd = '0;
      i_ExRegWr = 1'b0; i_MemRegWr = 1'b0; i_WbRegWr = 1'b0; i_ExIsLoad = 1'b0;
      i_ExResult = '0; i_MemResult = '0; i_WbData = '0;

      // Reset state
      step(); step();
      check("rst_vld",   32'(o_OpValid), 32'd0);
      check("rst_a",     o_OpA, 32'd0);
      check("rst_b",     o_OpB, 32'd0);
      check("rst_rd",    32'(o_OpRd), 32'd0);
      check("rst_ctrl",  32'(o_OpCtrl), 32'd0);
      check("rst_flags", 32'({o_OpRegWr, o_OpIsLoad}), 32'd0);
      i_Reset = 1'b0;
      step();

      // No hazard
      i_InstValid = 1'b1; i_InstRs1 = 5'd3; i_InstRs2 = 5'd4;
      i_InstUseRs1 = 1'b1; i_InstUseRs2 = 1'b1; i_InstRd = 5'd8; i_InstRegWr = 1'b1;
      i_InstCtrl = 16'h5A5A; i_RdDataA = 32'h11; i_RdDataB = 32'h22;
      #1;
      check("rdaddr_a", 32'(o_RdAddrA), 32'd3);
      check("rdaddr_b", 32'(o_RdAddrB), 32'd4);
      check("nohaz_rdy", 32'(o_InstReady), 32'd1);
      step();
      i_InstValid = 1'b0;
      check("nohaz_vld",  32'(o_OpValid), 32'd1);
      check("nohaz_a",    o_OpA, 32'h11);
      check("nohaz_b",    o_OpB, 32'h22);
      check("nohaz_rd",   32'(o_OpRd), 32'd8);
      check("nohaz_wr",   32'(o_OpRegWr), 32'd1);
      check("nohaz_ctrl", 32'(o_OpCtrl), 32'h5A5A);
      step();
      check("bubble_vld", 32'(o_OpValid), 32'd0);

      // x0 never matches; unused operand reads zero
      i_InstValid = 1'b1; i_InstRs1 = 5'd0; i_InstUseRs2 = 1'b0; i_InstRegWr = 1'b0;
      i_RdDataA = 32'h77; i_ExRd = 5'd0; i_ExRegWr = 1'b1; i_ExResult = 32'hFFFF;
      #1;
      check("x0_rdy", 32'(o_InstReady), 32'd1);
      step();
      check("x0_a",      o_OpA, 32'd0);
      check("unused_b",  o_OpB, 32'd0);

      // Priority EX > MEM > WB
      i_InstRs1 = 5'd5; i_RdDataA = 32'h5555;
      i_ExRd = 5'd5; i_ExResult = 32'hAAAA;
      i_MemRd = 5'd5; i_MemRegWr = 1'b1; i_MemResult = 32'hBBBB;
      i_WbRd = 5'd5; i_WbRegWr = 1'b1; i_WbData = 32'hCCCC;
      #1;
`ifdef OPFETCH_FORWARD_EN
      check("prio_rdy", 32'(o_InstReady), 32'd1);
      step();
      check("prio_ex", o_OpA, 32'hAAAA);
      i_ExRegWr = 1'b0;
      step();
      check("prio_mem", o_OpA, 32'hBBBB);
      i_MemRegWr = 1'b0;
      step();
      check("prio_wb", o_OpA, 32'hCCCC);
      i_WbRegWr = 1'b0;
`else
      check("haz_rdy", 32'(o_InstReady), 32'd0);
      step();
      check("haz_vld", 32'(o_OpValid), 32'd0);
      i_ExRegWr = 1'b0; i_MemRegWr = 1'b0; i_WbRegWr = 1'b0;
      #1;
      check("haz_clr_rdy", 32'(o_InstReady), 32'd1);
      step();
      check("haz_rf_a", o_OpA, 32'h5555);
`endif

      // Load-use
      i_InstUseRs1 = 1'b0; i_InstRs2 = 5'd7; i_InstUseRs2 = 1'b1; i_RdDataB = 32'h9999;
      i_InstRd = 5'd10; i_InstRegWr = 1'b1; i_InstIsLoad = 1'b1; i_InstCtrl = 16'h0C0C;
      i_ExRd = 5'd7; i_ExRegWr = 1'b1; i_ExIsLoad = 1'b1;
      #1;
      check("lu_rdy", 32'(o_InstReady), 32'd0);
      step();
      i_ExRegWr = 1'b0; i_ExIsLoad = 1'b0;
      i_MemRd = 5'd7; i_MemRegWr = 1'b1; i_MemResult = 32'h1234;
      #1;
`ifdef OPFETCH_FORWARD_EN
      check("lu_fwd_rdy", 32'(o_InstReady), 32'd1);
`else
      check("lu_mem_rdy", 32'(o_InstReady), 32'd0);
      step();
      i_MemRegWr = 1'b0;
      #1;
      check("lu_clr_rdy", 32'(o_InstReady), 32'd1);
`endif
      step();
      i_MemRegWr = 1'b0;
      check("lu_b",    o_OpB, EXP_B_HOLD);
      check("lu_load", 32'(o_OpIsLoad), 32'd1);

      // Backpressure then flush
      i_OpReady = 1'b0; i_InstRs1 = 5'd1; i_InstUseRs1 = 1'b1; i_RdDataA = 32'hDEAD;
      i_InstRd = 5'd3; i_InstIsLoad = 1'b0; i_InstCtrl = 16'h3333;
      #1;
      check("bp_rdy", 32'(o_InstReady), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_vld",  32'(o_OpValid), 32'd1);
         check("bp_b",    o_OpB, EXP_B_HOLD);
         check("bp_rd",   32'(o_OpRd), 32'd10);
         check("bp_ctrl", 32'(o_OpCtrl), 32'h0C0C);
      end
      i_Flush = 1'b1;
      #1;
      check("fl_rdy", 32'(o_InstReady), 32'd0);
      step();
      check("fl_vld", 32'(o_OpValid), 32'd0);
      check("fl_noacc_rd", 32'(o_OpRd), 32'd10);
      i_Flush = 1'b0; i_OpReady = 1'b1; i_InstUseRs2 = 1'b0;

      // WB match
      i_InstRs1 = 5'd9; i_RdDataA = 32'h4242; i_WbRd = 5'd9; i_WbRegWr = 1'b1; i_WbData = 32'h7777;
      #1;
`ifdef OPFETCH_FORWARD_EN
      check("wb_rdy", 32'(o_InstReady), 32'd1);
      step();
      check("wb_fwd_a", o_OpA, 32'h7777);
`else
      check("wb_stall_rdy", 32'(o_InstReady), 32'd0);
      step();
      check("wb_stall_vld", 32'(o_OpValid), 32'd0);
      i_WbRegWr = 1'b0;
      #1;
      check("wb_clr_rdy", 32'(o_InstReady), 32'd1);
      step();
      check("wb_rf_a", o_OpA, 32'h4242);
`endif
      i_WbRegWr = 1'b0;

      // Reset mid-packet
      i_InstValid = 1'b0; i_OpReady = 1'b0; i_Reset = 1'b1;
      step();
      check("rstmid_vld", 32'(o_OpValid), 32'd0);
      check("rstmid_a",   o_OpA, 32'd0);
      i_Reset = 1'b0;
      step();
      check("rstmid_idle", 32'(o_OpValid), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute stage that sits directly around the register file.
- Drives the register file's two read-address ports and captures the returned data.
- Resolves RAW hazards by forwarding from EX/MEM/WB or by stalling.
- Presents a registered operand packet to EX over a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/result width
ADDR_WIDTH, 5, register index width
CTRL_WIDTH, 16, opaque decoded-control bits passed through to EX

Ports:
i_Clock  in  1  clock, rising edge
i_Reset  in  1  reset, synchronous, active-high
i_Flush  in  1  kill incoming instruction and output packet (branch redirect)
i_InstValid  in  1  decoded instruction offered
o_InstReady  out  1  stage accepts instruction this cycle
i_InstRs1, i_InstRs2  in  ADDR_WIDTH  source register indices
i_InstUseRs1, i_InstUseRs2  in  1  source actually read
i_InstRd  in  ADDR_WIDTH  destination index
i_InstRegWr  in  1  instruction writes rd
i_InstIsLoad  in  1  instruction is a load
i_InstCtrl  in  CTRL_WIDTH  pass-through control
o_RdAddrA, o_RdAddrB  out  ADDR_WIDTH  register file read addresses (= i_InstRs1 / i_InstRs2, combinational)
i_RdDataA, i_RdDataB  in  DATA_WIDTH  register file read data (combinational, same cycle)
i_ExRd, i_MemRd, i_WbRd  in  ADDR_WIDTH  destination index in EX/MEM/WB
i_ExRegWr, i_MemRegWr, i_WbRegWr  in  1  stage holds a valid register write
i_ExIsLoad  in  1  EX instruction is a load (result not yet available)
i_ExResult, i_MemResult, i_WbData  in  DATA_WIDTH  forwardable values
o_OpValid  out  1  operand packet valid
i_OpReady  in  1  EX accepts packet
o_OpA, o_OpB  out  DATA_WIDTH  resolved operands
o_OpRd  out  ADDR_WIDTH  passed-through destination index
o_OpRegWr  out  1  passed-through register-write flag
o_OpIsLoad  out  1  passed-through load flag
o_OpCtrl  out  CTRL_WIDTH  passed-through control

Behaviour:
- Clock/reset: one clock i_Clock; reset i_Reset is synchronous, active-high.
- Reset: o_OpValid=0; o_OpA, o_OpB, o_OpRd, o_OpCtrl, o_OpRegWr, o_OpIsLoad all zero. Reset mid-packet drops the packet with no EX handshake.
- Source match: a source matches stage S when:
  - its Use bit is 1,
  - rs != 0,
  - S_RegWr = 1,
  - S_Rd = rs.
  - Index 0 never matches; an rs of 0 resolves to zero, like the register file.
- Forward priority, per operand: EX > MEM > WB > i_RdData. WB forwarding is mandatory because register file reads do not see a same-cycle write.
- Load-use stall: a match with EX while i_ExIsLoad=1 sets stall=1.
- Ready: o_InstReady = ~stall & ~i_Flush & (~o_OpValid | i_OpReady). This is combinational; no path from i_InstValid to o_InstReady.
- Accept: on i_InstValid & o_InstReady, the output register loads resolved operands plus pass-through fields, and o_OpValid<=1. Latency is 1 cycle from accept to o_OpValid.
- Hold: if o_OpValid & ~i_OpReady, all outputs hold stable.
- Bubble: if o_OpValid & i_OpReady and nothing is accepted, o_OpValid<=0.
- Flush: o_OpValid<=0 next cycle and no accept occurs. Flush dominates a simultaneous accept; reset dominates flush.
- Unused operand: an operand with Use=0 outputs zero.

Optional Feature:
Macro OPFETCH_FORWARD_EN.
- Defined: forwarding behaves as above; only load-use stalls.
- Undefined: no forwarding; operands come only from i_RdData. Any source match with EX, MEM or WB sets stall=1 (a WB match costs 1 stall cycle). The forward muxes are removed.

Decomposition:
- Shared package cpu_pkg: DATA_WIDTH/ADDR_WIDTH defaults, ZERO_REG constant, forward-select enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), op_packet_t struct (a, b, rd, regwr, isload, ctrl).
- One sub-module, operand_forward_mux: combinational match detection plus priority select. Instantiated twice (A, B); emits a per-operand stall request.

Test Plan:
- No hazard: rs1=3, rs2=4, RF returns 0x11/0x22, accept, i_OpReady=1 -> next cycle o_OpValid=1, o_OpA=0x11, o_OpB=0x22.
- Priority: EX rd=5 result 0xAAAA, MEM rd=5 0xBBBB, WB rd=5 0xCCCC, rs1=5 -> o_OpA=0xAAAA. Drop EX -> 0xBBBB. Drop MEM -> 0xCCCC.
- x0 protection: rs1=0 with EX rd=0, regwr=1, result 0xFFFF -> o_OpA=0, no stall.
- Load-use: EX load rd=7, incoming rs2=7 -> o_InstReady=0 for 1 cycle. Next cycle EX deasserts load, MEM rd=7 holds 0x1234 -> accepted, o_OpB=0x1234.
- Backpressure then flush: o_OpValid=1, i_OpReady=0 for 3 cycles -> outputs stable. Assert i_Flush with i_InstValid=1 -> o_OpValid=0 next cycle, instruction not accepted.
- OPFETCH_FORWARD_EN undefined: WB rd=9, rs1=9 -> one stall cycle, then o_OpA = i_RdDataA.
